// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver: frames scancodes, tracks modifiers, maps make codes to ASCII
// and queues them in a small FIFO drained one byte at a time toward the serial transmitter.
module ps2_keyboard #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       tx_busy,
  output logic       wr,
  output logic [7:0] char,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned TimeoutCycles = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
  localparam int unsigned PtrW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW          = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Synchronizers
  logic ps2c_q1, ps2c_q2, ps2c_q3, ps2d_q1, ps2d_q2;
  logic fall;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      {ps2c_q1, ps2c_q2, ps2c_q3} <= 3'b111;
      {ps2d_q1, ps2d_q2}          <= 2'b11;
    end else begin
      {ps2c_q1, ps2c_q2, ps2c_q3} <= {ps2c, ps2c_q1, ps2c_q2};
      {ps2d_q1, ps2d_q2}          <= {ps2d, ps2d_q1};
    end
  end

  assign fall = ps2c_q3 & ~ps2c_q2;

  // Frame FSM
  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            timed_out, frame_ok;

  assign timed_out = (state_q == StShift) && !fall && (tmo_q == TmoW'(TimeoutCycles));
  assign frame_ok  = ps2d_q2 && (^{shreg_q, par_q});

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      if (fall) begin
        tmo_q <= '0;
      end else if (tmo_q != TmoW'(TimeoutCycles)) begin
        tmo_q <= tmo_q + TmoW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    case (state_q)
      StIdle: begin
        if (fall && !ps2d_q2) begin
          state_d   = StShift;
          bit_cnt_d = 4'd1;
        end
      end
      StShift: begin
        if (fall) begin
          if (bit_cnt_q <= 4'd8) begin
            shreg_d = {ps2d_q2, shreg_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            par_d = ps2d_q2;
          end
          if (bit_cnt_q == 4'd10) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timed_out) begin
          state_d   = StIdle;
          bit_cnt_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == StIdle) begin
      frame_err_d = fall && ps2d_q2;
    end else if (fall && bit_cnt_q == 4'd10) begin
      byte_valid_d = frame_ok;
      frame_err_d  = !frame_ok;
    end else if (timed_out) begin
      frame_err_d = 1'b1;
    end
  end

  // Scancode lookup; shreg_q still holds the received byte while byte_valid_q is high
  logic [7:0] lut_plain, lut_shift, lut_char;
  logic       lut_letter;
  logic       brk_q, brk_d, ext_q, ext_d, lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
  logic       push_q, push_d;
  logic [7:0] push_data_q;

  always_comb begin
    lut_plain = 8'h00;
    lut_shift = 8'h00;
    case (shreg_q)
      8'h1C: lut_plain = "a";  8'h32: lut_plain = "b";  8'h21: lut_plain = "c";
      8'h23: lut_plain = "d";  8'h24: lut_plain = "e";  8'h2B: lut_plain = "f";
      8'h34: lut_plain = "g";  8'h33: lut_plain = "h";  8'h43: lut_plain = "i";
      8'h3B: lut_plain = "j";  8'h42: lut_plain = "k";  8'h4B: lut_plain = "l";
      8'h3A: lut_plain = "m";  8'h31: lut_plain = "n";  8'h44: lut_plain = "o";
      8'h4D: lut_plain = "p";  8'h15: lut_plain = "q";  8'h2D: lut_plain = "r";
      8'h1B: lut_plain = "s";  8'h2C: lut_plain = "t";  8'h3C: lut_plain = "u";
      8'h2A: lut_plain = "v";  8'h1D: lut_plain = "w";  8'h22: lut_plain = "x";
      8'h35: lut_plain = "y";  8'h1A: lut_plain = "z";
      8'h45: begin lut_plain = "0"; lut_shift = ")"; end
      8'h16: begin lut_plain = "1"; lut_shift = "!"; end
      8'h1E: begin lut_plain = "2"; lut_shift = "@"; end
      8'h26: begin lut_plain = "3"; lut_shift = "#"; end
      8'h25: begin lut_plain = "4"; lut_shift = "$"; end
      8'h2E: begin lut_plain = "5"; lut_shift = "%"; end
      8'h36: begin lut_plain = "6"; lut_shift = "^"; end
      8'h3D: begin lut_plain = "7"; lut_shift = "&"; end
      8'h3E: begin lut_plain = "8"; lut_shift = "*"; end
      8'h46: begin lut_plain = "9"; lut_shift = "("; end
      8'h29: begin lut_plain = 8'h20; lut_shift = 8'h20; end
      8'h5A: begin lut_plain = 8'h0D; lut_shift = 8'h0D; end
      8'h66: begin lut_plain = 8'h08; lut_shift = 8'h08; end
      8'h0D: begin lut_plain = 8'h09; lut_shift = 8'h09; end
      8'h76: begin lut_plain = 8'h1B; lut_shift = 8'h1B; end
      default: ;
    endcase
    lut_letter = (lut_plain >= 8'h61) && (lut_plain <= 8'h7A);
    if (lut_letter) begin
      lut_shift = lut_plain - 8'h20;
    end
    if (ctrl_q && lut_letter) begin
      lut_char = lut_plain & 8'h1F;
    end else if (lshift_q || rshift_q) begin
      lut_char = lut_shift;
    end else begin
      lut_char = lut_plain;
    end
  end

  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    ctrl_d   = ctrl_q;
    push_d   = 1'b0;
    if (byte_valid_q) begin
      if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q && shreg_q == 8'h12) begin
          lshift_d = !brk_q;
        end else if (!ext_q && shreg_q == 8'h59) begin
          rshift_d = !brk_q;
        end else if (shreg_q == 8'h14) begin
          ctrl_d = !brk_q;
        end else if (!brk_q && !ext_q && lut_char != 8'h00) begin
          push_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      {brk_q, ext_q, lshift_q, rshift_q, ctrl_q} <= 5'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
    end else begin
      {brk_q, ext_q, lshift_q, rshift_q, ctrl_q} <= {brk_d, ext_d, lshift_d, rshift_d, ctrl_d};
      push_q      <= push_d;
      push_data_q <= lut_char;
    end
  end

  // FIFO and output pacing
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            wr_q, overflow_q, full, pop, push_ok;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && !tx_busy && !wr_q;
  assign push_ok = push_q && (!full || pop);

  always_ff @(posedge clk25) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
      wr_q       <= pop;
      overflow_q <= push_q && full && !pop;
    end
  end

  assign wr        = pop;
  assign char      = pop ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
